// File: rtl/video_stream_source.sv
// rtl/video_stream_source.sv - frame/line timing and test-pattern pixel source (optional SRC_LFSR_NOISE_EN)
module video_stream_source #(
    parameter logic [11:0] IMG_HDISP     = 12'd640,
    parameter logic [11:0] IMG_VDISP     = 12'd480,
    parameter logic [11:0] H_BLANK       = 12'd160,
    parameter logic [11:0] V_GAP_LINES   = 12'd2,
    parameter logic [11:0] V_BACK_LINES  = 12'd10,
    parameter logic [11:0] V_FRONT_LINES = 12'd10,
    parameter logic [3:0]  CLKEN_DIV     = 4'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic [1:0] pattern_sel,
    output logic       busy,
    output logic       frame_done,
    output logic       img_vsync,
    output logic       img_href,
    output logic       img_clken,
    output logic [7:0] img_gray
);

    // Active and total line lengths can exceed 12 bits once multiplied by the pixel divider.
    localparam int          ACT_INT   = int'(IMG_HDISP) * int'(CLKEN_DIV);
    localparam int          LINE_INT  = ACT_INT + int'(H_BLANK) - 1;
    localparam logic [15:0] ACT_CYC   = ACT_INT[15:0];
    localparam logic [15:0] LINE_LAST = LINE_INT[15:0];
    localparam logic [3:0]  SUB_LAST  = CLKEN_DIV - 4'd1;
    localparam logic [11:0] HALF_X    = {1'b0, IMG_HDISP[11:1]};

    typedef enum logic [2:0] {IDLE, GAP, BACK, ACTIVE, FRONT} state_t;

    state_t      state, state_n;
    logic [15:0] hcnt, hcnt_n;
    logic [3:0]  sub, sub_n;
    logic [11:0] xcnt, xcnt_n;
    logic [11:0] vcnt, vcnt_n;
    logic [1:0]  pat, pat_n;
    logic [11:0] region_last;
    logic        gap_entry;
    logic        line_end;
    logic        busy_n, frame_done_n, vsync_n, href_n, clken_n;
    logic [7:0]  gray_n;
`ifdef SRC_LFSR_NOISE_EN
    logic [15:0] lfsr, lfsr_n;
`endif

    assign line_end = (hcnt == LINE_LAST);

    // State, counters and registered outputs; outputs are precomputed from next-state values so they align with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hcnt       <= '0;
            sub        <= '0;
            xcnt       <= '0;
            vcnt       <= '0;
            pat        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            img_vsync  <= 1'b0;
            img_href   <= 1'b0;
            img_clken  <= 1'b0;
            img_gray   <= '0;
`ifdef SRC_LFSR_NOISE_EN
            lfsr       <= 16'hACE1;
`endif
        end else begin
            state      <= state_n;
            hcnt       <= hcnt_n;
            sub        <= sub_n;
            xcnt       <= xcnt_n;
            vcnt       <= vcnt_n;
            pat        <= pat_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            img_vsync  <= vsync_n;
            img_href   <= href_n;
            img_clken  <= clken_n;
            img_gray   <= gray_n;
`ifdef SRC_LFSR_NOISE_EN
            lfsr       <= lfsr_n;
`endif
        end
    end

    // Region sequencing, line/pixel counters, and next values of every output.
    always_comb begin
        state_n     = state;
        hcnt_n      = hcnt;
        sub_n       = sub;
        xcnt_n      = xcnt;
        vcnt_n      = vcnt;
        pat_n       = pat;
        gap_entry   = 1'b0;
        gray_n      = 8'h00;

        case (state)
            GAP:     region_last = V_GAP_LINES - 12'd1;
            BACK:    region_last = V_BACK_LINES - 12'd1;
            ACTIVE:  region_last = IMG_VDISP - 12'd1;
            FRONT:   region_last = V_FRONT_LINES - 12'd1;
            default: region_last = 12'd0;
        endcase

        if (state == IDLE) begin
            if (start) begin
                state_n   = GAP;
                gap_entry = 1'b1;
            end
        end else if (line_end) begin
            hcnt_n = '0;
            sub_n  = '0;
            xcnt_n = '0;
            if (vcnt == region_last) begin
                vcnt_n = '0;
                case (state)
                    GAP:     state_n = BACK;
                    BACK:    state_n = ACTIVE;
                    ACTIVE:  state_n = FRONT;
                    default: begin
                        if (continuous) begin
                            state_n   = GAP;
                            gap_entry = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                endcase
            end else begin
                vcnt_n = vcnt + 12'd1;
            end
        end else begin
            hcnt_n = hcnt + 16'd1;
            if (sub == SUB_LAST) begin
                sub_n  = '0;
                xcnt_n = xcnt + 12'd1;
            end else begin
                sub_n = sub + 4'd1;
            end
        end

        if (gap_entry) begin
            pat_n = pattern_sel;
        end

        busy_n       = (state_n != IDLE);
        frame_done_n = (state_n == FRONT) && (hcnt_n == LINE_LAST) && (vcnt_n == V_FRONT_LINES - 12'd1);
        vsync_n      = (state_n == BACK) || (state_n == ACTIVE) || (state_n == FRONT);
        href_n       = (state_n == ACTIVE) && (hcnt_n < ACT_CYC);
        clken_n      = href_n && (sub_n == 4'd0);

`ifdef SRC_LFSR_NOISE_EN
        lfsr_n = lfsr;
        if (gap_entry) begin
            lfsr_n = 16'hACE1;
        end else if (clken_n) begin
            lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
`endif

        if (clken_n) begin
            case (pat_n)
                2'd0:    gray_n = xcnt_n[7:0];
                2'd1:    gray_n = vcnt_n[7:0];
                2'd2:    gray_n = (xcnt_n[3] ^ vcnt_n[3]) ? 8'hFF : 8'h00;
`ifdef SRC_LFSR_NOISE_EN
                default: gray_n = lfsr[7:0];
`else
                default: gray_n = (xcnt_n < HALF_X) ? 8'h00 : 8'hFF;
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_video_stream_source.sv
// tb/tb_video_stream_source.sv - randomized model-based bench for video_stream_source
module tb_video_stream_source;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       cont_a = 1'b0, cont_b = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       busy_a, fd_a, vs_a, href_a, ck_a;
    logic       busy_b, fd_b, vs_b, href_b, ck_b;
    logic [7:0] gray_a, gray_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    video_stream_source #(
        .IMG_HDISP(12'd8), .IMG_VDISP(12'd4), .H_BLANK(12'd4),
        .V_GAP_LINES(12'd1), .V_BACK_LINES(12'd1), .V_FRONT_LINES(12'd1), .CLKEN_DIV(4'd1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .pattern_sel(pattern_sel),
        .busy(busy_a), .frame_done(fd_a), .img_vsync(vs_a), .img_href(href_a), .img_clken(ck_a),
        .img_gray(gray_a)
    );

    video_stream_source #(
        .IMG_HDISP(12'd8), .IMG_VDISP(12'd4), .H_BLANK(12'd4),
        .V_GAP_LINES(12'd1), .V_BACK_LINES(12'd1), .V_FRONT_LINES(12'd1), .CLKEN_DIV(4'd3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b), .pattern_sel(pattern_sel),
        .busy(busy_b), .frame_done(fd_b), .img_vsync(vs_b), .img_href(href_b), .img_clken(ck_b),
        .img_gray(gray_b)
    );

    // Observation word: {busy, frame_done, vsync, href, clken, gray}
    function automatic logic [12:0] obs(input int sel);
        if (sel != 0) return {busy_b, fd_b, vs_b, href_b, ck_b, gray_b};
        return {busy_a, fd_a, vs_a, href_a, ck_a, gray_a};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic logic [7:0] model_gray(input logic [1:0] p, input int x, input int y, input logic [15:0] l);
        logic [7:0] xv, yv;
        xv = x[7:0];
        yv = y[7:0];
        case (p)
            2'd0: return xv;
            2'd1: return yv;
            2'd2: return (xv[3] ^ yv[3]) ? 8'hFF : 8'h00;
            default: begin
`ifdef SRC_LFSR_NOISE_EN
                return l[7:0];
`else
                return (x < 4) ? 8'h00 : 8'hFF;
`endif
            end
        endcase
    endfunction

    task automatic drive_start(input int sel, input logic v);
        if (sel != 0) start_b = v; else start_a = v;
    endtask

    task automatic drive_cont(input int sel, input logic v);
        if (sel != 0) cont_b = v; else cont_a = v;
    endtask

    // Starts a frame sequence and compares every cycle against the timing model; frame f spans 7 lines.
    task automatic run_frames(input int sel, input int nframes, input logic [1:0] pat0, input bit poke_start,
                              output int fd_count, output logic [7:0] first_gray);
        int          div, lp, total, errs, bad_t, l, h, x, y;
        logic [1:0]  pat, next_pat;
        logic [15:0] lf;
        logic [12:0] got, exp, bad_got, bad_exp;
        logic        act, hr, ck;
        bit          got_first;
        div = (sel != 0) ? 3 : 1;
        lp = 8 * div + 4;
        total = 7 * lp;
        pat = pat0;
        pattern_sel = pat0;
        drive_cont(sel, nframes > 1);
        fd_count = 0;
        first_gray = 8'h00;
        got_first = 0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        drive_start(sel, 1'b1);
        @(negedge clk);
        drive_start(sel, 1'b0);
        for (int f = 0; f < nframes; f++) begin
            lf = 16'hACE1;
            errs = 0;
            bad_t = 0;
            bad_got = '0;
            bad_exp = '0;
            next_pat = pat;
            for (int t = 0; t < total; t++) begin
                l = t / lp;
                h = t % lp;
                act = (l >= 2) && (l < 6);
                hr = act && (h < 8 * div);
                ck = hr && (h % div == 0);
                x = h / div;
                y = l - 2;
                exp = {1'b1, t == total - 1, l >= 1, hr, ck, ck ? model_gray(pat, x, y, lf) : 8'h00};
                if (ck) lf = lfsr_step(lf);
                got = obs(sel);
                if (got[11]) fd_count++;
                if (got[8] && !got_first) begin
                    got_first = 1;
                    first_gray = got[7:0];
                end
                if (got !== exp) begin
                    if (errs == 0) begin
                        bad_t = t;
                        bad_got = got;
                        bad_exp = exp;
                    end
                    errs++;
                end
                if (t == 20) begin
                    next_pat = 2'($urandom_range(0, 3));
                    pattern_sel = next_pat;
                end
                if (poke_start && f == 0 && t == 5) drive_start(sel, 1'b1);
                if (poke_start && f == 0 && t == 6) drive_start(sel, 1'b0);
                if (f == nframes - 1 && t == total / 2) drive_cont(sel, 1'b0);
                @(negedge clk);
            end
            n_tests++;
            if (errs != 0) begin
                n_fail++;
                $display("FAIL frame sel=%0d f=%0d pat=%0d: %0d bad cycles, first at t=%0d got=%h expected=%h",
                         sel, f, pat, errs, bad_t, bad_got, bad_exp);
            end
            pat = next_pat;
        end
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (obs(sel) !== 13'd0) errs++;
            @(negedge clk);
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL idle_after sel=%0d: %0d non-idle cycles, expected 0", sel, errs);
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if (obs(0) !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_a: got=%h expected=0", obs(0));
        end
        n_tests++;
        if (obs(1) !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_b: got=%h expected=0", obs(1));
        end
    endtask

    task automatic test_single_frame;
        int fdc;
        logic [7:0] fg;
        run_frames(0, 1, 2'd0, 0, fdc, fg);
        n_tests++;
        if (fdc !== 1) begin
            n_fail++;
            $display("FAIL single_frame_done: got=%0d expected=1", fdc);
        end
    endtask

    task automatic test_ramps;
        int fdc;
        logic [7:0] fg;
        run_frames(0, 1, 2'd1, 0, fdc, fg);
        n_tests++;
        if (fg !== 8'h00) begin
            n_fail++;
            $display("FAIL vramp_first: got=%h expected=00", fg);
        end
        run_frames(0, 1, 2'd2, 0, fdc, fg);
    endtask

    task automatic test_clken_div;
        int fdc;
        logic [7:0] fg;
        run_frames(1, 1, 2'($urandom_range(0, 3)), 0, fdc, fg);
        n_tests++;
        if (fdc !== 1) begin
            n_fail++;
            $display("FAIL div3_frame_done: got=%0d expected=1", fdc);
        end
    endtask

    task automatic test_continuous;
        int fdc;
        logic [7:0] fg;
        run_frames(0, 3, 2'($urandom_range(0, 2)), 1, fdc, fg);
        n_tests++;
        if (fdc !== 3) begin
            n_fail++;
            $display("FAIL continuous_frame_done: got=%0d expected=3", fdc);
        end
    endtask

    task automatic test_abort;
        int fdc, stop_t;
        logic [7:0] fg;
        logic [12:0] o;
        pattern_sel = 2'($urandom_range(0, 3));
        stop_t = 2 * 12 + 12 * $urandom_range(0, 3) + $urandom_range(0, 7);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (stop_t) @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_before: got=%b expected=1", busy_a);
        end
        rst_n = 1'b0;
        #1;
        o = obs(0);
        n_tests++;
        if (o !== 13'd0) begin
            n_fail++;
            $display("FAIL abort_outputs_zero: got=%h expected=0", o);
        end
        fdc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fd_a) fdc++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (fd_a || busy_a) fdc++;
        end
        n_tests++;
        if (fdc !== 0) begin
            n_fail++;
            $display("FAIL abort_no_frame_done: got=%0d active cycles expected=0", fdc);
        end
        run_frames(0, 1, 2'($urandom_range(0, 3)), 0, fdc, fg);
        n_tests++;
        if (fdc !== 1) begin
            n_fail++;
            $display("FAIL abort_clean_frame_done: got=%0d expected=1", fdc);
        end
    endtask

    task automatic test_edge_pattern;
        int fdc;
        logic [7:0] fg;
        run_frames(0, 1, 2'd3, 0, fdc, fg);
        n_tests++;
`ifdef SRC_LFSR_NOISE_EN
        if (fg !== 8'hE1) begin
            n_fail++;
            $display("FAIL pattern3_first_gray: got=%h expected=e1", fg);
        end
`else
        if (fg !== 8'h00) begin
            n_fail++;
            $display("FAIL pattern3_first_gray: got=%h expected=00", fg);
        end
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_frame();
        test_ramps();
        test_clken_div();
        test_continuous();
        test_abort();
        test_edge_pattern();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
